// File: rtl/ravenoc_pkg.sv
// Shared RaveNoC types and default mesh configuration for the local-port
// packet injector and its router binding.
package ravenoc_pkg;

   localparam int NOC_CFG_X       = 2;
   localparam int NOC_CFG_Y       = 2;
   localparam int MAX_SZ_PKT      = 256;
   localparam int FLIT_DATA_WIDTH = 32;
   localparam int FLIT_WIDTH      = FLIT_DATA_WIDTH + 2;

   // A one-wide mesh still needs one address bit so every field has a width.
   function automatic int minWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int X_W      = minWidth(NOC_CFG_X);
   localparam int Y_W      = minWidth(NOC_CFG_Y);
   localparam int PKT_SZ_W = $clog2(MAX_SZ_PKT);
   localparam int RSVD_W   = FLIT_DATA_WIDTH - X_W - Y_W - PKT_SZ_W;

   typedef enum logic [1:0] {
      HEAD_FLIT = 2'b00,
      BODY_FLIT = 2'b01,
      TAIL_FLIT = 2'b10
   } flit_type_t;

   typedef struct packed {
      logic [X_W-1:0]      x_dest;
      logic [Y_W-1:0]      y_dest;
      logic [PKT_SZ_W-1:0] pkt_size;
      logic [RSVD_W-1:0]   rsvd;
   } s_head_flit_t;

   typedef struct packed {
      logic                  fvalid;
      logic [FLIT_WIDTH-1:0] flit;
   } s_flit_req_t;

   typedef struct packed {
      logic req_ready;
   } s_flit_resp_t;

endpackage

// File: rtl/flit_out_reg.sv
// One-entry valid/ready register: accepts a new flit whenever it is empty or
// its current flit is being taken, and holds everything stable on a stall.
module flit_out_reg #(
   parameter int WIDTH = ravenoc_pkg::FLIT_WIDTH
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_free,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   assign o_free  = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Data is only rewritten on a load, so a drained register keeps its last
   // flit harmlessly behind a low valid.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_free) begin
         r_valid <= i_load;
         if (i_load) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/ravenoc_pkt_injector.sv
// Local-port packet transmitter: turns a descriptor plus payload words into
// HEAD/BODY/TAIL flits on the router's recv_flit valid/ready interface.
module ravenoc_pkt_injector #(
   parameter int ROUTER_X_ID     = 0,
   parameter int ROUTER_Y_ID     = 0,
   parameter int NOC_CFG_X       = ravenoc_pkg::NOC_CFG_X,
   parameter int NOC_CFG_Y       = ravenoc_pkg::NOC_CFG_Y,
   parameter int MAX_SZ_PKT      = ravenoc_pkg::MAX_SZ_PKT,
   parameter int FLIT_DATA_WIDTH = ravenoc_pkg::FLIT_DATA_WIDTH,
   localparam int X_W            = ravenoc_pkg::minWidth(NOC_CFG_X),
   localparam int Y_W            = ravenoc_pkg::minWidth(NOC_CFG_Y),
   localparam int PKT_SZ_W       = $clog2(MAX_SZ_PKT),
   localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + 2
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       pkt_valid_i,
   output logic                       pkt_ready_o,
   input  logic [X_W-1:0]             pkt_x_dest_i,
   input  logic [Y_W-1:0]             pkt_y_dest_i,
   input  logic [PKT_SZ_W-1:0]        pkt_len_i,
   input  logic                       data_valid_i,
   output logic                       data_ready_o,
   input  logic [FLIT_DATA_WIDTH-1:0] data_i,
   output logic                       fout_valid_o,
   output logic [FLIT_WIDTH-1:0]      fout_data_o,
   input  logic                       fout_ready_i,
   output logic                       pkt_err_o,
   output logic                       pkt_done_o,
   output logic                       busy_o
);

   localparam int RSVD_W = FLIT_DATA_WIDTH - X_W - Y_W - PKT_SZ_W;
   localparam logic [X_W:0] X_LIM = (X_W + 1)'(NOC_CFG_X);
   localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(NOC_CFG_Y);

   // The owning router must sit inside the mesh it is configured for.
   if (ROUTER_X_ID >= NOC_CFG_X || ROUTER_Y_ID >= NOC_CFG_Y) begin : g_badRouterId
      $error("ravenoc_pkt_injector: router ID outside the configured mesh");
   end

   typedef enum logic {
      IDLE,
      PAYLOAD
   } state_t;

   state_t                    r_state;
   state_t                    w_nextState;
   logic [PKT_SZ_W-1:0]       r_counter;
   logic [PKT_SZ_W-1:0]       w_nextCounter;
   logic                      r_err;
   logic                      r_done;
   logic                      r_last;
   logic                      w_free;
   logic                      w_descHs;
   logic                      w_wordHs;
   logic                      w_illegal;
   logic                      w_load;
   logic                      w_loadLast;
   logic [FLIT_WIDTH-1:0]     w_loadData;
   logic [FLIT_DATA_WIDTH-1:0] w_head;

   ravenoc_pkg::s_flit_req_t  w_flitReq;
   ravenoc_pkg::s_flit_resp_t w_flitResp;

   assign w_flitResp.req_ready = fout_ready_i;
   assign fout_valid_o         = w_flitReq.fvalid;
   assign fout_data_o          = w_flitReq.flit;

   assign pkt_ready_o  = (r_state == IDLE) && w_free;
   assign data_ready_o = (r_state == PAYLOAD) && w_free;
   assign w_descHs     = pkt_valid_i && pkt_ready_o;
   assign w_wordHs     = data_valid_i && data_ready_o;
   assign w_illegal    = ({1'b0, pkt_x_dest_i} >= X_LIM) || ({1'b0, pkt_y_dest_i} >= Y_LIM);
   assign w_head       = {pkt_x_dest_i, pkt_y_dest_i, pkt_len_i, {RSVD_W{1'b0}}};

   assign pkt_err_o  = r_err;
   assign pkt_done_o = r_done;
   assign busy_o     = (r_state != IDLE) || fout_valid_o;

   // State, remaining-word counter and the one-cycle status pulses.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state   <= IDLE;
         r_counter <= '0;
         r_err     <= 1'b0;
         r_done    <= 1'b0;
         r_last    <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_counter <= w_nextCounter;
         r_err     <= w_descHs && w_illegal;
         r_done    <= fout_valid_o && fout_ready_i && r_last;
         if (w_free) begin
            r_last <= w_loadLast;
         end
      end
   end

   // Next-state and flit-load decode; the counter is at least 1 in PAYLOAD,
   // so the decrement cannot wrap.
   always_comb begin
      w_nextState   = r_state;
      w_nextCounter = r_counter;
      w_load        = 1'b0;
      w_loadLast    = 1'b0;
      w_loadData    = '0;
      case (r_state)
         IDLE: begin
            if (w_descHs && !w_illegal) begin
               w_load        = 1'b1;
               w_loadData    = {ravenoc_pkg::HEAD_FLIT, w_head};
               w_loadLast    = (pkt_len_i == '0);
               w_nextCounter = pkt_len_i;
               if (pkt_len_i != '0) begin
                  w_nextState = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (w_wordHs) begin
               w_load        = 1'b1;
               w_nextCounter = r_counter - PKT_SZ_W'(1);
               if (r_counter == PKT_SZ_W'(1)) begin
                  w_loadData  = {ravenoc_pkg::TAIL_FLIT, data_i};
                  w_loadLast  = 1'b1;
                  w_nextState = IDLE;
               end else begin
                  w_loadData = {ravenoc_pkg::BODY_FLIT, data_i};
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   flit_out_reg #(
      .WIDTH (FLIT_WIDTH)
   ) u_flitOutReg (
      .clk     (clk),
      .arst    (arst),
      .i_load  (w_load),
      .i_data  (w_loadData),
      .o_free  (w_free),
      .i_ready (w_flitResp.req_ready),
      .o_valid (w_flitReq.fvalid),
      .o_data  (w_flitReq.flit)
   );

endmodule
